// File: rtl/if_pc_gen.sv
// Fetch-address generator: holds the fetch PC, steps it one fetch window per cycle,
// and applies prioritised redirects, latching one while fetch is stalled.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FETCH_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Ctrl_Stall,
  input  logic [3:0]  Flush,
  input  logic        issue_select,
  input  logic        Csr_ExcpFlag,
  input  logic [31:0] Csr_ExcpAddr,
  input  logic        EX_BranchFlag_0,
  input  logic [31:0] EX_BranchAddr_0,
  input  logic        EX_BranchFlag_1,
  input  logic [31:0] EX_BranchAddr_1,
  input  logic        Decode_16BitFlag_0,
  input  logic        Decode_16BitFlag_1,
  input  logic [31:0] Id_Pc,
  output logic [31:0] If_Pc,
  output logic        If_PcValid,
  output logic        Pcgen_RedirectPend
);

  logic        started;
  logic        pendVld;
  logic [31:0] pendAddr;
  logic        liveVld;
  logic [31:0] rawTgt;
  logic [31:0] liveTgt;
  logic        unusedBits;

  assign unusedBits = ^{Ctrl_Stall[4:1], Flush[3:1]};

  always_comb begin
    liveVld = 1'b1;
    rawTgt  = '0;
    if (Csr_ExcpFlag)            rawTgt = Csr_ExcpAddr;
    else if (EX_BranchFlag_0)    rawTgt = EX_BranchAddr_0;
    else if (EX_BranchFlag_1)    rawTgt = EX_BranchAddr_1;
    else if (Decode_16BitFlag_0) rawTgt = Id_Pc + 32'd2;
    // Slot 1 compressed implies a 32-bit slot 0 ahead of it.
    else if (Decode_16BitFlag_1) rawTgt = Id_Pc + 32'd6;
    else if (issue_select)       rawTgt = Id_Pc + 32'd4;
    else                         liveVld = 1'b0;
    liveTgt = {rawTgt[31:1], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      If_Pc      <= RESET_PC;
      If_PcValid <= 1'b0;
      started    <= 1'b0;
      pendVld    <= 1'b0;
      pendAddr   <= '0;
    end else if (!started) begin
      // First edge out of reset only raises the request; the PC holds.
      started    <= 1'b1;
      If_PcValid <= ~Flush[0];
    end else begin
      If_PcValid <= ~Flush[0];
      if (!Ctrl_Stall[0]) begin
        if (liveVld) begin
          If_Pc   <= liveTgt;
          pendVld <= 1'b0;
        end else if (pendVld) begin
          If_Pc   <= pendAddr;
          pendVld <= 1'b0;
        end else begin
          If_Pc <= If_Pc + 32'(FETCH_BYTES);
        end
      end else if (liveVld) begin
        pendAddr <= liveTgt;
        pendVld  <= 1'b1;
      end
    end
  end

  assign Pcgen_RedirectPend = pendVld;

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: directed vector table, reset sequences, then random
// stimulus checked against a priority-list/queue model of the fetch PC.
module tb_if_pc_gen;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Ctrl_Stall;
  logic [3:0]  Flush;
  logic        issue_select;
  logic        Csr_ExcpFlag;
  logic [31:0] Csr_ExcpAddr;
  logic        EX_BranchFlag_0;
  logic [31:0] EX_BranchAddr_0;
  logic        EX_BranchFlag_1;
  logic [31:0] EX_BranchAddr_1;
  logic        Decode_16BitFlag_0;
  logic        Decode_16BitFlag_1;
  logic [31:0] Id_Pc;
  logic [31:0] If_Pc;
  logic        If_PcValid;
  logic        Pcgen_RedirectPend;

  int errors = 0;
  int checks = 0;

  if_pc_gen #(.RESET_PC(RST_PC), .FETCH_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .Ctrl_Stall(Ctrl_Stall), .Flush(Flush),
    .issue_select(issue_select), .Csr_ExcpFlag(Csr_ExcpFlag), .Csr_ExcpAddr(Csr_ExcpAddr),
    .EX_BranchFlag_0(EX_BranchFlag_0), .EX_BranchAddr_0(EX_BranchAddr_0),
    .EX_BranchFlag_1(EX_BranchFlag_1), .EX_BranchAddr_1(EX_BranchAddr_1),
    .Decode_16BitFlag_0(Decode_16BitFlag_0), .Decode_16BitFlag_1(Decode_16BitFlag_1),
    .Id_Pc(Id_Pc), .If_Pc(If_Pc), .If_PcValid(If_PcValid),
    .Pcgen_RedirectPend(Pcgen_RedirectPend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  stall;
    logic [3:0]  flush;
    logic        isel;
    logic        csr;
    logic [31:0] csrA;
    logic        b0;
    logic [31:0] b0A;
    logic        b1;
    logic [31:0] b1A;
    logic        d0;
    logic        d1;
    logic [31:0] idPc;
    logic [31:0] expPc;
    logic        expPend;
    logic        expValid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [4:0] st, logic [3:0] fl, logic is, logic cs, logic [31:0] csA,
                              logic b0, logic [31:0] b0A, logic b1, logic [31:0] b1A,
                              logic d0, logic d1, logic [31:0] idp,
                              logic [31:0] ePc, logic ePend, logic eVal);
    vec_t v;
    v.stall = st; v.flush = fl; v.isel = is; v.csr = cs; v.csrA = csA;
    v.b0 = b0; v.b0A = b0A; v.b1 = b1; v.b1A = b1A; v.d0 = d0; v.d1 = d1; v.idPc = idp;
    v.expPc = ePc; v.expPend = ePend; v.expValid = eVal;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Ctrl_Stall = v.stall; Flush = v.flush; issue_select = v.isel;
    Csr_ExcpFlag = v.csr; Csr_ExcpAddr = v.csrA;
    EX_BranchFlag_0 = v.b0; EX_BranchAddr_0 = v.b0A;
    EX_BranchFlag_1 = v.b1; EX_BranchAddr_1 = v.b1A;
    Decode_16BitFlag_0 = v.d0; Decode_16BitFlag_1 = v.d1; Id_Pc = v.idPc;
  endtask

  task automatic idle();
    drive(mk(5'b0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkAll(input string tag, input logic [31:0] ePc, input logic ePend, input logic eVal);
    chk({tag, ".pc"}, If_Pc, ePc);
    chk({tag, ".pend"}, {31'b0, Pcgen_RedirectPend}, {31'b0, ePend});
    chk({tag, ".valid"}, {31'b0, If_PcValid}, {31'b0, eVal});
  endtask

  // Reference: first raised flag in priority order picks its target; pending is a 0/1-entry queue.
  function automatic logic [32:0] refTarget(input vec_t v);
    logic        fl[6];
    logic [31:0] ad[6];
    fl = '{v.csr, v.b0, v.b1, v.d0, v.d1, v.isel};
    ad = '{v.csrA, v.b0A, v.b1A, v.idPc + 2, v.idPc + 6, v.idPc + 4};
    for (int i = 0; i < 6; i++)
      if (fl[i]) return {1'b1, ad[i] & 32'hFFFF_FFFE};
    return '0;
  endfunction

  logic [31:0] mPc;
  logic        mValid;
  logic [31:0] pendQ[$];

  task automatic modelEdge(input vec_t v);
    logic [32:0] t;
    t = refTarget(v);
    if (v.stall[0]) begin
      if (t[32]) begin pendQ.delete(); pendQ.push_back(t[31:0]); end
    end else if (t[32]) begin
      mPc = t[31:0]; pendQ.delete();
    end else if (pendQ.size() != 0) begin
      mPc = pendQ.pop_front();
    end else begin
      mPc = mPc + 32'd8;
    end
    mValid = !v.flush[0];
  endtask

  initial begin
    vec_t v;
    logic [32:0] unusedT;

    // Reset and first-edge hold
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chkAll("reset", RST_PC, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chkAll("firstEdge", RST_PC, 1'b0, 1'b1);

    //        stall     flush   is cs csA      b0 b0A           b1 b1A      d0 d1 idPc      expPc          pend val
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h8000_0008, 0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h8000_0010, 0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 1, 32'h100, 1, 32'h200,      0, 0,       0, 0, 0,        32'h100,       0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       1, 32'h200,      1, 32'h300, 0, 0, 0,        32'h200,       0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       1, 0, 32'h1000, 32'h1002,      0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 1, 32'h1000, 32'h1006,      0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 1, 0, 0,       0, 0,            0, 0,       0, 0, 32'h1000, 32'h1004,      0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       1, 32'h303,      0, 0,       0, 0, 0,        32'h302,       0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h30A,       0, 1));
    tbl.push_back(mk(5'b00000, 4'h1, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h312,       0, 0));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h31A,       0, 1));
    tbl.push_back(mk(5'b00001, 4'h0, 0, 0, 0,       1, 32'h400,      0, 0,       0, 0, 0,        32'h31A,       1, 1));
    tbl.push_back(mk(5'b00001, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h31A,       1, 1));
    tbl.push_back(mk(5'b00001, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h31A,       1, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h400,       0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h408,       0, 1));
    tbl.push_back(mk(5'b00001, 4'h0, 0, 0, 0,       1, 32'h400,      0, 0,       0, 0, 0,        32'h408,       1, 1));
    tbl.push_back(mk(5'b00001, 4'h0, 0, 0, 0,       1, 32'h500,      0, 0,       0, 0, 0,        32'h408,       1, 1));
    tbl.push_back(mk(5'b00001, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h408,       1, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h500,       0, 1));
    tbl.push_back(mk(5'b00001, 4'h0, 0, 0, 0,       1, 32'h400,      0, 0,       0, 0, 0,        32'h500,       1, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 1, 32'h700, 0, 0,            0, 0,       0, 0, 0,        32'h700,       0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h708,       0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       1, 32'hFFFF_FFF8, 0, 0,      0, 0, 0,        32'hFFFF_FFF8, 0, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h0,         0, 1));
    tbl.push_back(mk(5'b11111, 4'h0, 0, 0, 0,       0, 0,            1, 32'hA1,  0, 0, 0,        32'h0,         1, 1));
    tbl.push_back(mk(5'b11111, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'h0,         1, 1));
    tbl.push_back(mk(5'b00000, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'hA0,        0, 1));
    tbl.push_back(mk(5'b11110, 4'h0, 0, 0, 0,       0, 0,            0, 0,       0, 0, 0,        32'hA8,        0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      chkAll($sformatf("vec%0d", i), tbl[i].expPc, tbl[i].expPend, tbl[i].expValid);
    end

    // Async reset while a redirect is pending: clears without a clock edge
    drive(mk(5'b00001, 4'h0, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chkAll("preAbort", 32'hA8, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chkAll("asyncAbort", RST_PC, 1'b0, 1'b0);
    idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chkAll("abortFirst", RST_PC, 1'b0, 1'b1);
    @(posedge clk); #1;
    chkAll("abortSecond", RST_PC + 32'd8, 1'b0, 1'b1);

    // Randomised run against the reference model
    mPc = RST_PC + 32'd8;
    mValid = 1'b1;
    pendQ.delete();
    for (int n = 0; n < 400; n++) begin
      v = mk(($urandom_range(0, 2) == 0) ? (5'($urandom) | 5'b1) : (5'($urandom) & 5'b11110),
             ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom) & 4'hE,
             $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom,
             $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0, $urandom,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom, 0, 0, 0);
      drive(v);
      modelEdge(v);
      @(posedge clk); #1;
      chkAll($sformatf("rnd%0d", n), mPc, pendQ.size() != 0, mValid);
    end
    unusedT = refTarget(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
